// File: rtl/alb_mss_mem_ibp_arb_pkg.sv
// -----------------------------------------------------------------------------
// alb_mss_mem_ibp_arb_pkg
//   Shared types and helpers for the two-master IBP arbiter.
//   - arb_state_e   : command arbiter state (IDLE, HOLD, LOCKED)
//   - cmd_w / wr_w  : packed command / write-data channel widths
//   - *_pos         : bit positions of read, lock and last in the channels
//   Optional feature macro used by the arbiter: ALB_MSS_MEM_IBP_ARB_LOCK_EN
// -----------------------------------------------------------------------------
package alb_mss_mem_ibp_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD   = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    // wrap(1) + data_size(3) + burst_size(4) + prot(2) + cache(4)
    // + lock(1) + excl(1) + read(1)
    localparam int CMD_FIXED_W = 17;

    // last is the LSB of {data, mask, last}
    localparam int WR_LAST_POS = 0;

    function automatic int cmd_w(input int a_w, input int id_w,
                                 input int u_w, input int rg_w);
        return a_w + id_w + u_w + rg_w + CMD_FIXED_W;
    endfunction

    function automatic int wr_w(input int d_w);
        return d_w + d_w / 8 + 1;
    endfunction

    // read is the MSB of the command channel
    function automatic int cmd_read_pos(input int cw);
        return cw - 1;
    endfunction

    // lock sits just above {excl, id, user, region}
    function automatic int cmd_lock_pos(input int id_w, input int u_w,
                                        input int rg_w);
        return rg_w + u_w + id_w + 1;
    endfunction

endpackage

// File: rtl/alb_mss_mem_ibp_arb_wq.sv
// -----------------------------------------------------------------------------
// alb_mss_mem_ibp_arb_wq
//   1-bit wide index FIFO recording which master owns each accepted write
//   command whose data has not yet completed.
//   Ports:
//     clk, rst_a     clock, asynchronous active-high reset
//     push_i         store push_idx_i (ignored when full without a pop)
//     push_idx_i     master index to store
//     pop_i          drop the head entry (ignored when empty)
//     full_o         count == DEPTH
//     empty_o        count == 0
//     head_o         index at the head of the queue
//     count_o        current occupancy
// -----------------------------------------------------------------------------
module alb_mss_mem_ibp_arb_wq #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_a,
    input  logic          push_i,
    input  logic          push_idx_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic          head_o,
    output logic [AW:0]   count_o
);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full queue is only legal when the head leaves this cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_idx_i;
    end

endmodule

// File: rtl/alb_mss_mem_ibp_arb.sv
// -----------------------------------------------------------------------------
// alb_mss_mem_ibp_arb
//   Two-master IBP arbiter sharing one downstream command + write-data port.
//   Round-robin on the command channel, grant held until accepted; write
//   data steered in accepted-write-command order via a master-index queue.
//   Optional feature macro: ALB_MSS_MEM_IBP_ARB_LOCK_EN
//     defined   : an accepted lock=1 command pins the grant until that
//                 master's next accepted lock=0 command
//     undefined : lock is passed through with no arbitration effect
//   Ports:
//     clk, rst_a                       clock, async active-high reset
//     mN_cmd_valid/accept/chnl         master N command channel (N=0,1)
//     mN_wr_valid/accept/chnl          master N write-data channel
//     o_cmd_valid/accept/chnl          downstream command channel
//     o_cmd_grant                      master currently driving o_cmd_chnl
//     o_wr_valid/accept/chnl           downstream write-data channel
// -----------------------------------------------------------------------------
module alb_mss_mem_ibp_arb
    import alb_mss_mem_ibp_arb_pkg::*;
#(
    parameter  int a_w      = 32,
    parameter  int id_w     = 5,
    parameter  int u_w      = 1,
    parameter  int rg_w     = 1,
    parameter  int d_w      = 32,
    parameter  int WQ_DEPTH = 4,
    localparam int CW       = cmd_w(a_w, id_w, u_w, rg_w),
    localparam int WW       = wr_w(d_w)
) (
    input  logic          clk,
    input  logic          rst_a,

    input  logic          m0_cmd_valid,
    output logic          m0_cmd_accept,
    input  logic [CW-1:0] m0_cmd_chnl,
    input  logic          m0_wr_valid,
    output logic          m0_wr_accept,
    input  logic [WW-1:0] m0_wr_chnl,

    input  logic          m1_cmd_valid,
    output logic          m1_cmd_accept,
    input  logic [CW-1:0] m1_cmd_chnl,
    input  logic          m1_wr_valid,
    output logic          m1_wr_accept,
    input  logic [WW-1:0] m1_wr_chnl,

    output logic          o_cmd_valid,
    input  logic          o_cmd_accept,
    output logic [CW-1:0] o_cmd_chnl,
    output logic          o_cmd_grant,
    output logic          o_wr_valid,
    input  logic          o_wr_accept,
    output logic [WW-1:0] o_wr_chnl
);

    localparam int RD_B  = cmd_read_pos(CW);
    localparam int CNT_W = $clog2(WQ_DEPTH) + 1;
`ifdef ALB_MSS_MEM_IBP_ARB_LOCK_EN
    localparam int LK_B  = cmd_lock_pos(id_w, u_w, rg_w);
`endif

    arb_state_e       state_q, state_d;
    logic             hold_m_q, hold_m_d;
    logic             rr_last_q, rr_last_d;

    logic             elig0, elig1;
    logic             grant, cmd_vld, cmd_fire;
    logic [CW-1:0]    g_chnl;
    logic             g_read;
`ifdef ALB_MSS_MEM_IBP_ARB_LOCK_EN
    logic             g_lock;
`endif

    logic             wq_full, wq_empty, wq_head, wq_occupied;
    logic [CNT_W-1:0] wq_count;
    logic             wq_push, wq_pop;
    logic             head_wv, head_last, head_pop;
    logic             bypass, src, src_vld, src_wv, wr_pop;
    logic [WW-1:0]    src_chnl;

    // A write command is only eligible while the queue can take its index.
    assign elig0 = m0_cmd_valid & (m0_cmd_chnl[RD_B] | ~wq_full);
    assign elig1 = m1_cmd_valid & (m1_cmd_chnl[RD_B] | ~wq_full);

    // State register
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q   <= ARB_IDLE;
            hold_m_q  <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_m_q  <= hold_m_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        hold_m_d  = hold_m_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ARB_IDLE: begin
                if (cmd_vld) begin
                    hold_m_d = grant;
                    if (cmd_fire) begin
                        rr_last_d = grant;
`ifdef ALB_MSS_MEM_IBP_ARB_LOCK_EN
                        if (g_lock) state_d = ARB_LOCKED;
`endif
                    end else begin
                        state_d = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                if (cmd_fire) begin
                    rr_last_d = hold_m_q;
                    state_d   = ARB_IDLE;
`ifdef ALB_MSS_MEM_IBP_ARB_LOCK_EN
                    if (g_lock) state_d = ARB_LOCKED;
`endif
                end
            end
`ifdef ALB_MSS_MEM_IBP_ARB_LOCK_EN
            ARB_LOCKED: begin
                if (cmd_fire && !g_lock) begin
                    rr_last_d = hold_m_q;
                    state_d   = ARB_IDLE;
                end
            end
`endif
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output logic: grant selection
    always_comb begin
        grant   = 1'b0;
        cmd_vld = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                grant   = (elig0 & elig1) ? ~rr_last_q : (elig1 & ~elig0);
                cmd_vld = elig0 | elig1;
            end
            default: begin
                // HOLD/LOCKED: grant pinned regardless of the other master
                // or of queue occupancy.
                grant   = hold_m_q;
                cmd_vld = hold_m_q ? m1_cmd_valid : m0_cmd_valid;
            end
        endcase
    end

    assign g_chnl = grant ? m1_cmd_chnl : m0_cmd_chnl;
    assign g_read = g_chnl[RD_B];
`ifdef ALB_MSS_MEM_IBP_ARB_LOCK_EN
    assign g_lock = g_chnl[LK_B];
`endif

    // Head-of-queue completion, computed without the bypass path so the
    // full-queue command gating below does not loop back through it.
    assign head_wv   = wq_head ? m1_wr_valid : m0_wr_valid;
    assign head_last = wq_head ? m1_wr_chnl[WR_LAST_POS] : m0_wr_chnl[WR_LAST_POS];
    assign head_pop  = wq_occupied & head_wv & head_last & o_wr_accept;

    // A held write grant into a full queue only completes when a slot frees.
    assign cmd_fire = cmd_vld & o_cmd_accept & (g_read | ~wq_full | head_pop);

    assign o_cmd_valid   = cmd_vld;
    assign o_cmd_grant   = grant;
    assign o_cmd_chnl    = cmd_vld ? g_chnl : '0;
    assign m0_cmd_accept = cmd_fire & ~grant;
    assign m1_cmd_accept = cmd_fire &  grant;

    // Write steering: queue head first, otherwise the write command being
    // accepted right now may carry its data in the same cycle.
    assign wq_occupied = (wq_count != '0);
    assign bypass      = wq_empty & cmd_fire & ~g_read;
    assign src         = wq_occupied ? wq_head : grant;
    assign src_vld     = wq_occupied | bypass;
    assign src_wv      = src ? m1_wr_valid : m0_wr_valid;
    assign src_chnl    = src ? m1_wr_chnl : m0_wr_chnl;

    assign o_wr_valid   = src_vld & src_wv;
    assign o_wr_chnl    = o_wr_valid ? src_chnl : '0;
    assign m0_wr_accept = o_wr_accept & src_vld & ~src;
    assign m1_wr_accept = o_wr_accept & src_vld &  src;

    assign wr_pop  = o_wr_valid & o_wr_accept & src_chnl[WR_LAST_POS];
    // A bypassed single-beat write completes immediately and never queues.
    assign wq_push = cmd_fire & ~g_read & ~(bypass & wr_pop);
    assign wq_pop  = wr_pop & wq_occupied;

    alb_mss_mem_ibp_arb_wq #(
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk        (clk),
        .rst_a      (rst_a),
        .push_i     (wq_push),
        .push_idx_i (grant),
        .pop_i      (wq_pop),
        .full_o     (wq_full),
        .empty_o    (wq_empty),
        .head_o     (wq_head),
        .count_o    (wq_count)
    );

endmodule

// File: doc/alb_mss_mem_ibp_arb.md
# alb_mss_mem_ibp_arb

Two-master IBP arbiter that shares one downstream IBP command and write-data port, typically the input of an `alb_mss_mem_ibp_buf` in front of a memory model. It applies round-robin arbitration on the command channel and holds each grant stable until accepted. Write data is steered to the downstream port in accepted-write-command order through a small master-index queue, so write data never overtakes its own command.

## Interface
Parameters:
- `a_w`, 32, address width
- `id_w`, 5, command id width
- `u_w`, 1, user width
- `rg_w`, 1, region width
- `d_w`, 32, write data width
- `WQ_DEPTH`, 4, pending-write queue depth (power of 2, ≥2)
- derived `CW` = a_w+id_w+u_w+rg_w+17; `WW` = d_w+d_w/8+1

Ports:
- `clk`  in  1  clock; one clock, all logic on rising edge
- `rst_a`  in  1  reset, asynchronous, active-high
- `mN_cmd_valid` / `mN_cmd_accept`  in/out  1  master N (N=0,1) command handshake
- `mN_cmd_chnl`  in  CW  packed {read, addr, wrap, data_size, burst_size, prot, cache, lock, excl, id, user, region}; read is MSB
- `mN_wr_valid` / `mN_wr_accept`  in/out  1  master N write-data handshake
- `mN_wr_chnl`  in  WW  packed {data, mask, last}; last is LSB
- `o_cmd_valid` / `o_cmd_accept`  out/in  1  downstream command handshake
- `o_cmd_chnl`  out  CW  selected command
- `o_cmd_grant`  out  1  index of the master currently driving `o_cmd_chnl`
- `o_wr_valid` / `o_wr_accept`  out/in  1  downstream write handshake
- `o_wr_chnl`  out  WW  selected write beat

## Operation
- Eligibility: a master is eligible when `cmd_valid=1` and (read=1 or queue not full).
- Arbiter states:
  - IDLE: pick the eligible master. If both are eligible, pick the master ≠ `rr_last`.
  - If the pick is accepted in the same cycle, stay in IDLE and set `rr_last` = winner.
  - Otherwise go to HOLD(winner).
- HOLD(m): the grant is fixed to m, irrespective of the other master and of the queue filling. On `o_cmd_accept`, return to IDLE and set `rr_last`=m.
- `mN_cmd_accept` = `o_cmd_accept` & (grant==N) & `o_cmd_valid`. The non-granted master sees accept=0.
- Write queue: on an accepted write command, push the master index. Pop on `o_wr_valid & o_wr_accept & last`.
- Write steering:
  - Queue non-empty: the head index selects the source master.
  - Queue empty but a write command is accepted this cycle: the granted master is the source (bypass).
  - Otherwise `o_wr_valid=0` and both `mN_wr_accept=0`.
- `mN_wr_accept` = `o_wr_accept` & (source==N) & source valid.
- Simultaneous push and pop: occupancy is unchanged and pointers advance independently. Bypass with pop in the same cycle leaves the queue empty.
- Write data from a non-source master is back-pressured. Multi-beat bursts stay on one source until `last` is accepted.

## Timing
- Command and write paths are combinational, with zero added latency. Registered state is the arbiter state, `rr_last`, queue pointers and count.
- Reset values:
  - `o_cmd_valid=0`, `o_wr_valid=0`, all `mN_*_accept=0`, `o_cmd_grant=0`.
  - Data outputs are 0 when not valid.
  - Arbiter in IDLE, `rr_last=1` (so m0 wins the first tie), queue empty.
- Reset asserted mid-burst drops all pending state immediately. Masters must re-issue.
- Queue full (count==WQ_DEPTH): write commands are ineligible. A held write grant still presents valid but is not accepted unless a pop frees a slot in the same cycle; the push is then allowed.
- `o_cmd_valid` never deasserts before accept once raised, provided the granted master holds valid (IBP rule).

## Configuration
- `ALB_MSS_MEM_IBP_ARB_LOCK_EN` defined:
  - An accepted command with lock=1 from master m pins the grant to m (LOCKED state).
  - The grant stays pinned until a command from m with lock=0 is accepted; then IDLE, `rr_last`=m.
  - The other master is starved while LOCKED.
- Undefined: the lock bit is passed through only and has no arbitration effect. No LOCKED state is present.

## Structure
- Package `alb_mss_mem_ibp_arb_pkg`:
  - Arbiter state enum (IDLE, HOLD, LOCKED).
  - Functions computing CW/WW from the widths.
  - Bit-position constants for read, lock and last within the packed channels.
- Sub-module `alb_mss_mem_ibp_arb_wq`: a 1-bit-wide, WQ_DEPTH-deep index FIFO with full, empty, head and count outputs. It is reset by `rst_a`.

## Test plan
- Both masters issue reads continuously with `o_cmd_accept=1` → grants alternate m0,m1,m0,…; the first grant goes to m0 after reset.
- m1 write held with `o_cmd_accept=0` for 5 cycles while m0 raises valid → grant stays m1, `m0_cmd_accept=0` until m1 is accepted.
- m0 4-beat write command, then m1 2-beat write command, with data offered by m1 first → m1 wr_accept stays 0 until m0's last beat; output data order is m0×4, m1×2.
- Queue empty, write command and first beat from m0 in the same cycle → both accepted that cycle; a single-beat write leaves the queue empty.
- Fill the queue with 4 writes, stall wr → 5th write not accepted; reads from the other master still granted; popping one slot admits the 5th write.
- With LOCK_EN: m0 sends lock=1, lock=1, lock=0 while m1 requests → m1 is granted only after m0's lock=0 command is accepted.
